pc_redirect_unit: RTL and testbench

//  Fetch-side consumer of the branch decision. Holds the architectural fetch PC and

---
 rtl/pc_redirect_unit_pkg.sv | 19 +
 rtl/pc_redirect_unit_sat_counter.sv | 19 +
 rtl/pc_redirect_unit.sv | 131 +++++++++++++
 tb/tb_pc_redirect_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_unit_pkg.sv
// Shared fetch-core definitions: FSM encodings, PC step and branch func3 codes.
package pc_redirect_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

  localparam int PC_STEP = 4;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/pc_redirect_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: sequential advance, taken-branch redirect with wrong-path flush,
// and trap hold on misaligned targets until the handler vector arrives.
//
// state    | meaning
// ST_RUN   | normal fetch, branches accepted
// ST_FLUSH | post-redirect, killing wrong-path IF/ID slots, branches ignored
// ST_TRAP  | misaligned target seen, fetch invalid until trap_ack_i
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_PC     = '0,
  parameter int               FLUSH_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            br_valid_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            trap_ack_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o,
  output logic [15:0]     taken_cnt_o
);

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_adv;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            flush_q, flush_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic            taken_inc;

  assign pc_adv = stall_i ? pc_q : (pc_q + XLEN'(PC_STEP));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      flush_q    <= 1'b0;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      valid_q    <= valid_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    flush_d    = 1'b0;
    valid_d    = 1'b1;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;
    taken_inc  = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A taken branch wins over stall: the redirect must not be lost.
        if (br_valid_i && br_taken_i) begin
          flush_d = 1'b1;
          if (br_target_i[1:0] == 2'b00) begin
            pc_d      = br_target_i;
            cnt_d     = CNT_LOAD;
            taken_inc = 1'b1;
            state_d   = ST_FLUSH;
          end else begin
            mis_d      = 1'b1;
            mis_addr_d = br_target_i;
            valid_d    = 1'b0;
            state_d    = ST_TRAP;
          end
        end else begin
          pc_d = pc_adv;
        end
      end
      ST_FLUSH: begin
        pc_d = pc_adv;
        if (cnt_q == 3'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d   = cnt_q - 3'd1;
          flush_d = 1'b1;
        end
      end
      ST_TRAP: begin
        valid_d = 1'b0;
        if (trap_ack_i) begin
          pc_d    = trap_vec_i & ~XLEN'(3);
          valid_d = 1'b1;
          flush_d = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  sat_counter #(.WIDTH(16)) u_taken_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (taken_inc),
    .cnt_o (taken_cnt_o)
  );

  assign pc_o            = pc_q;
  assign pc_valid_o      = valid_q;
  assign flush_o         = flush_q;
  assign misalign_o      = mis_q;
  assign misalign_addr_o = mis_addr_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed vector table, hand sequences for wrap and
// async reset, a small saturating-counter check, then random traffic vs a model.
module tb_pc_redirect_unit;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, bv = 1'b0, bt = 1'b0, ack = 1'b0;
  logic [31:0] tgt = '0, vec = '0;
  logic [31:0] pc, maddr;
  logic        pc_valid, flush, mis;
  logic [15:0] tcnt;
  logic        sat_inc = 1'b0;
  logic [3:0]  sat_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_redirect_unit #(.XLEN(32), .RESET_PC(32'h0), .FLUSH_CYCLES(FC)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_i         (stall),
    .br_valid_i      (bv),
    .br_taken_i      (bt),
    .br_target_i     (tgt),
    .trap_ack_i      (ack),
    .trap_vec_i      (vec),
    .pc_o            (pc),
    .pc_valid_o      (pc_valid),
    .flush_o         (flush),
    .misalign_o      (mis),
    .misalign_addr_o (maddr),
    .taken_cnt_o     (tcnt)
  );

  sat_counter #(.WIDTH(4)) u_sat (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (sat_inc),
    .cnt_o (sat_cnt)
  );

  typedef struct {
    logic        stall, bv, bt;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] vec;
    logic [31:0] e_pc;
    logic        e_v, e_f, e_m;
    logic [31:0] e_ma;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[16];

  // reference model: remaining flush cycles and a trapped flag
  logic [31:0] m_pc, m_ma;
  logic        m_valid, m_trap, m_mis;
  int          m_left, m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic v, input logic t, input logic [31:0] tg,
                        input logic a, input logic [31:0] vc);
    stall = s; bv = v; bt = t; tgt = tg; ack = a; vec = vc;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 1'b0; m_left = 0; m_trap = 1'b0;
    m_mis = 1'b0; m_ma = 32'h0; m_cnt = 0;
  endtask

  task automatic model_step();
    m_mis = 1'b0;
    if (m_trap) begin
      if (ack) begin
        m_pc = {vec[31:2], 2'b00}; m_valid = 1'b1; m_left = FC; m_trap = 1'b0;
      end else begin
        m_left = 0;
      end
    end else if (m_left > 0) begin
      m_left--;
      m_valid = 1'b1;
      if (!stall) m_pc = m_pc + 32'd4;
    end else begin
      m_valid = 1'b1;
      if (bv && bt) begin
        if (tgt % 4 == 0) begin
          m_pc = tgt; m_left = FC;
          if (m_cnt < 65535) m_cnt++;
        end else begin
          m_mis = 1'b1; m_ma = tgt; m_valid = 1'b0; m_left = 1; m_trap = 1'b1;
        end
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    //         stall bv bt tgt            ack vec     pc            v  f  m  maddr          cnt
    tbl[0]  = '{0, 0, 0, 32'h0,   0, 32'h0,  32'h4,   1, 0, 0, 32'h0,   16'd0};
    tbl[1]  = '{0, 0, 0, 32'h0,   0, 32'h0,  32'h8,   1, 0, 0, 32'h0,   16'd0};
    tbl[2]  = '{0, 0, 0, 32'h0,   0, 32'h0,  32'hC,   1, 0, 0, 32'h0,   16'd0};
    tbl[3]  = '{0, 0, 0, 32'h0,   0, 32'h0,  32'h10,  1, 0, 0, 32'h0,   16'd0};
    tbl[4]  = '{1, 0, 0, 32'h0,   0, 32'h0,  32'h10,  1, 0, 0, 32'h0,   16'd0};
    tbl[5]  = '{0, 1, 0, 32'h300, 0, 32'h0,  32'h14,  1, 0, 0, 32'h0,   16'd0};
    tbl[6]  = '{1, 1, 1, 32'h100, 0, 32'h0,  32'h100, 1, 1, 0, 32'h0,   16'd1};
    tbl[7]  = '{0, 1, 1, 32'h200, 0, 32'h0,  32'h104, 1, 1, 0, 32'h0,   16'd1};
    tbl[8]  = '{0, 0, 0, 32'h0,   0, 32'h0,  32'h108, 1, 0, 0, 32'h0,   16'd1};
    tbl[9]  = '{0, 0, 0, 32'h0,   0, 32'h0,  32'h10C, 1, 0, 0, 32'h0,   16'd1};
    tbl[10] = '{0, 1, 1, 32'h102, 0, 32'h0,  32'h10C, 0, 1, 1, 32'h102, 16'd1};
    tbl[11] = '{1, 1, 1, 32'h400, 0, 32'h0,  32'h10C, 0, 0, 0, 32'h102, 16'd1};
    tbl[12] = '{0, 0, 0, 32'h0,   1, 32'h83, 32'h80,  1, 1, 0, 32'h102, 16'd1};
    tbl[13] = '{1, 0, 0, 32'h0,   0, 32'h0,  32'h80,  1, 1, 0, 32'h102, 16'd1};
    tbl[14] = '{0, 0, 0, 32'h0,   0, 32'h0,  32'h84,  1, 0, 0, 32'h102, 16'd1};
    tbl[15] = '{0, 1, 1, 32'h40,  0, 32'h0,  32'h40,  1, 1, 0, 32'h102, 16'd2};

    do_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, pc_valid}, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_mis", {31'b0, mis}, 32'h0);
    check("rst_maddr", maddr, 32'h0);
    check("rst_cnt", {16'b0, tcnt}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].stall, tbl[i].bv, tbl[i].bt, tbl[i].tgt, tbl[i].ack, tbl[i].vec);
      tick();
      check($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
      check($sformatf("tbl%0d_valid", i), {31'b0, pc_valid}, {31'b0, tbl[i].e_v});
      check($sformatf("tbl%0d_flush", i), {31'b0, flush}, {31'b0, tbl[i].e_f});
      check($sformatf("tbl%0d_mis", i), {31'b0, mis}, {31'b0, tbl[i].e_m});
      check($sformatf("tbl%0d_maddr", i), maddr, tbl[i].e_ma);
      check($sformatf("tbl%0d_cnt", i), {16'b0, tcnt}, {16'b0, tbl[i].e_cnt});
    end

    // PC wrap: redirect near the top of the address space and let it run over
    set_in(0, 0, 0, 0, 0, 0);
    tick(); tick();
    set_in(0, 1, 1, 32'hFFFF_FFF4, 0, 0);
    tick();
    check("wrap_redirect", pc, 32'hFFFF_FFF4);
    set_in(0, 0, 0, 0, 0, 0);
    tick(); tick();
    check("wrap_top", pc, 32'hFFFF_FFFC);
    check("wrap_flush_done", {31'b0, flush}, 32'h0);
    tick();
    check("wrap_zero", pc, 32'h0);

    // async reset in the middle of a flush window
    set_in(0, 1, 1, 32'h500, 0, 0);
    tick();
    check("arst_pre_flush", {31'b0, flush}, 32'h1);
    set_in(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_flush", {31'b0, flush}, 32'h0);
    check("arst_valid", {31'b0, pc_valid}, 32'h0);
    check("arst_cnt", {16'b0, tcnt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("arst_after_pc", pc, 32'h4);
    check("arst_after_flush", {31'b0, flush}, 32'h0);
    check("arst_after_valid", {31'b0, pc_valid}, 32'h1);

    // saturation behaviour of the counter (narrow instance)
    sat_inc = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("sat_14", {28'b0, sat_cnt}, 32'd14);
    for (int i = 0; i < 6; i++) tick();
    check("sat_hold", {28'b0, sat_cnt}, 32'd15);
    sat_inc = 1'b0;

    // randomized traffic against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom % 10);
      stall = ($urandom % 4) == 0;
      bv    = ($urandom % 2) == 1;
      bt    = ($urandom % 2) == 1;
      if (r < 7)       tgt = $urandom & 32'hFFFF_FFFC;
      else if (r == 7) tgt = 32'hFFFF_FFF8;
      else             tgt = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      ack = ($urandom % 4) == 0;
      vec = $urandom;
      tick();
      model_step();
      check("rnd_pc", pc, m_pc);
      check("rnd_valid", {31'b0, pc_valid}, {31'b0, m_valid});
      check("rnd_flush", {31'b0, flush}, {31'b0, (m_left > 0)});
      check("rnd_mis", {31'b0, mis}, {31'b0, m_mis});
      check("rnd_maddr", maddr, m_ma);
      check("rnd_cnt", {16'b0, tcnt}, 32'(m_cnt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
